pool_max_2x2: RTL and testbench
===============================

Name: pool_max_2x2

Overview:
- Downstream consumer of two line-pair buffers (top row, bottom row) in the CNN pooling path.
- Reads two horizontally adjacent pixels from each buffer per cycle and computes the signed 2x2 max.
- Streams one pooled pixel per read into the next layer.
- Sequences whole line pairs, signals upstream when a pair is consumed, and flags end of frame.

Parameters:
INTEGER_BITS, 9, integer bits of signed two's-complement fixed-point pixel
FIXED_POINT_BITS, 4, fractional bits; pixel width W = INTEGER_BITS+FIXED_POINT_BITS (13)
LINE_WIDTH, 30, input pixels per line; must be even; reads per line pair R = LINE_WIDTH/2
NUM_LINES, 30, input lines per frame; must be even; line pairs per frame P = NUM_LINES/2

Ports:
i_clk  in  1  clock, all logic rising-edge
i_rst_n  in  1  asynchronous active-low reset
i_top_pair  in  2W  top-row pixel pair; [2W-1:W] = left pixel, [W-1:0] = right pixel
i_bot_pair  in  2W  bottom-row pixel pair, same packing
i_lines_ready  in  1  both buffers hold a complete line; sampled only in IDLE
o_rd_data  out  1  read strobe to both buffers; pairs are sampled on the same edge
o_data  out  W  pooled pixel, signed
o_data_valid  out  1  o_data valid this cycle
o_intr  out  1  one-cycle pulse when a line pair is fully consumed (upstream refill request)
o_frame_done  out  1  one-cycle pulse after the last line pair of the frame

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; state IDLE; col_cnt = 0, row_cnt = 0; pipeline valids cleared. Applies immediately, including mid-line.
- All comparisons are signed two's complement over the full W bits. On a tie, either operand may be selected (values are equal). No width growth.
- FSM states:
  - IDLE: o_rd_data=0. If i_lines_ready=1, go to READ next cycle.
  - READ: o_rd_data=1 every cycle. Pairs are sampled on each edge where o_rd_data=1. col_cnt increments per read. After read number R (col_cnt==R-1), clear col_cnt and go to DRAIN. i_lines_ready is ignored here.
  - DRAIN: o_rd_data=0; wait 2 cycles for the pipeline to empty, then go to LINE_DONE.
  - LINE_DONE: o_intr=1 for this cycle. If row_cnt==P-1, clear row_cnt and go to DONE; else increment row_cnt and go to IDLE.
  - DONE: o_frame_done=1 for this cycle, then go to IDLE.
- Pipeline, 2 stages:
  - Stage 1 (on the read edge): registers mt = max(top L, top R), mb = max(bot L, bot R), and v1 = 1.
  - Stage 2 (next edge): o_data = max(mt, mb), o_data_valid = v1.
  - Latency: o_data_valid rises 2 cycles after the first o_rd_data cycle.
  - Exactly R consecutive valid outputs per line pair; P*R outputs per frame.
- Output cadence:
  - No backpressure; the consumer must accept one pixel per cycle.
  - o_data holds its last value when o_data_valid=0.
- Boundary conditions:
  - i_lines_ready already high on return to IDLE: READ starts the next cycle. Minimum gap between line pairs = DRAIN(2) + LINE_DONE(1) + IDLE(1).
  - i_lines_ready dropping during READ: no effect; the line pair completes.
  - o_intr and o_frame_done are never high in the same cycle. o_intr precedes o_frame_done by exactly 1 cycle on the final pair.

Test Plan:
- Reset values: hold i_rst_n=0 with random inputs -> all outputs 0. Assert reset mid-READ -> o_rd_data and o_data_valid drop to 0 asynchronously. After release, with i_lines_ready=1, READ restarts with col_cnt=0 and the first valid output comes 3 cycles after release.
- Single line pair, positive ramp (LINE_WIDTH=30):
  - Stimulus: top pair k = {2k, 2k+1}, bottom pair k = {2k+30, 2k+31} (integer values, <<4 in fixed point).
  - Response: 15 outputs o_data = 2k+31 for k=0..14. First valid 2 cycles after the first o_rd_data. Exactly 15 o_rd_data cycles. o_intr pulses 3 cycles after the last read.
- Negative and mixed signs:
  - top={-5.0,-1.25}, bot={-3.0,-8.0} -> -1.25 (13'h1FEC).
  - top={-1,0}, bot={-2,-3} -> 0. Confirms signed compare.
- Ties: all four inputs equal to 13'h0A5 -> output 13'h0A5.
- Full frame (NUM_LINES=30), i_lines_ready tied high:
  - 225 valid outputs; 15 o_intr pulses; one o_frame_done exactly 1 cycle after the 15th o_intr.
  - row_cnt wraps to 0; the next frame proceeds identically.
- i_lines_ready gating: held low -> o_rd_data stays 0 indefinitely. Toggled low during READ -> the read burst is still exactly 15 cycles.

Source files
------------

// File: rtl/pool_max_2x2.sv
// pool_max_2x2: signed 2x2 max pooling over two line-pair buffers.
// The FSM reads LINE_WIDTH/2 pixel pairs per line pair from both buffers. A
// two-stage pipeline reduces each 2x2 window to one pooled pixel. Upstream is
// told when a line pair is consumed and when the frame is finished.
module pool_max_2x2 #(
  parameter int INTEGER_BITS     = 9,
  parameter int FIXED_POINT_BITS = 4,
  parameter int LINE_WIDTH       = 30,
  parameter int NUM_LINES        = 30,
  localparam int W               = INTEGER_BITS + FIXED_POINT_BITS
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [2*W-1:0] i_top_pair,
  input  logic [2*W-1:0] i_bot_pair,
  input  logic           i_lines_ready,
  output logic           o_rd_data,
  output logic [W-1:0]   o_data,
  output logic           o_data_valid,
  output logic           o_intr,
  output logic           o_frame_done
);

  localparam int R     = LINE_WIDTH / 2;
  localparam int P     = NUM_LINES / 2;
  localparam int COL_W = (R > 1) ? $clog2(R) : 1;
  localparam int ROW_W = (P > 1) ? $clog2(P) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(R - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(P - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_LINE_DONE,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [COL_W-1:0] col_cnt_reg;
  logic [ROW_W-1:0] row_cnt_reg;
  logic             drain_cnt_reg;

  // Row 0 is the top buffer and row 1 is the bottom buffer. Both rows get the same reduction.
  logic [1:0][2*W-1:0] pair_in;
  logic [1:0][W-1:0]   row_max_next;

  assign pair_in[0] = i_top_pair;
  assign pair_in[1] = i_bot_pair;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_row_max
      logic signed [W-1:0] left_pix;
      logic signed [W-1:0] right_pix;

      assign left_pix          = pair_in[gi][2*W-1:W];
      assign right_pix         = pair_in[gi][W-1:0];
      assign row_max_next[gi]  = (left_pix > right_pix) ? left_pix : right_pix;
    end
  endgenerate

  logic signed [W-1:0] mt_reg;
  logic signed [W-1:0] mb_reg;
  logic                v1_reg;
  logic signed [W-1:0] pool_max_next;

  assign pool_max_next = (mt_reg > mb_reg) ? mt_reg : mb_reg;

  // Line-pair sequencer: issues the read burst, waits for the pipeline to drain, then pulses intr or frame_done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= S_IDLE;
      col_cnt_reg   <= '0;
      row_cnt_reg   <= '0;
      drain_cnt_reg <= 1'b0;
      o_rd_data     <= 1'b0;
      o_intr        <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      o_intr       <= 1'b0;
      o_frame_done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (i_lines_ready) begin
            state_reg   <= S_READ;
            col_cnt_reg <= '0;
            o_rd_data   <= 1'b1;
          end
        end
        S_READ: begin
          if (col_cnt_reg == COL_LAST) begin
            col_cnt_reg   <= '0;
            drain_cnt_reg <= 1'b0;
            o_rd_data     <= 1'b0;
            state_reg     <= S_DRAIN;
          end else begin
            col_cnt_reg <= col_cnt_reg + COL_W'(1);
          end
        end
        S_DRAIN: begin
          // The second drain cycle lets the last pixel leave stage 2 before the refill request.
          if (drain_cnt_reg) begin
            state_reg <= S_LINE_DONE;
            o_intr    <= 1'b1;
          end else begin
            drain_cnt_reg <= 1'b1;
          end
        end
        S_LINE_DONE: begin
          if (row_cnt_reg == ROW_LAST) begin
            row_cnt_reg  <= '0;
            o_frame_done <= 1'b1;
            state_reg    <= S_DONE;
          end else begin
            row_cnt_reg <= row_cnt_reg + ROW_W'(1);
            state_reg   <= S_IDLE;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          o_rd_data <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the per-row maxima on every read edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mt_reg <= '0;
      mb_reg <= '0;
      v1_reg <= 1'b0;
    end else begin
      v1_reg <= o_rd_data;
      if (o_rd_data) begin
        mt_reg <= row_max_next[0];
        mb_reg <= row_max_next[1];
      end
    end
  end

  // Stage 2: combine the row maxima. o_data holds its last value between valid pixels.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
    end else begin
      o_data_valid <= v1_reg;
      if (v1_reg) begin
        o_data <= pool_max_next;
      end
    end
  end

endmodule

// File: tb/tb_pool_max_2x2.sv
// tb_pool_max_2x2: directed checks of the 2x2 max pooling block.
// Inputs come from a small line-buffer model. Outputs are logged on the falling edge.
module tb_pool_max_2x2;

  localparam int W    = 13;
  localparam int R    = 15;
  localparam int MAXN = 2048;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic [2*W-1:0] i_top_pair;
  logic [2*W-1:0] i_bot_pair;
  logic           i_lines_ready = 1'b0;
  logic           o_rd_data;
  logic [W-1:0]   o_data;
  logic           o_data_valid;
  logic           o_intr;
  logic           o_frame_done;

  pool_max_2x2 #(
    .INTEGER_BITS    (9),
    .FIXED_POINT_BITS(4),
    .LINE_WIDTH      (30),
    .NUM_LINES       (30)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_top_pair   (i_top_pair),
    .i_bot_pair   (i_bot_pair),
    .i_lines_ready(i_lines_ready),
    .o_rd_data    (o_rd_data),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_intr       (o_intr),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [2*W-1:0] top_mem [R];
  logic [2*W-1:0] bot_mem [R];
  logic [2*W-1:0] idle_top = '0;
  logic [2*W-1:0] idle_bot = '0;
  int             feed_idx = 0;

  // Line-buffer model: present pair k while a read is pending, and restart at pair 0 between bursts.
  always @(negedge i_clk) begin
    if (o_rd_data) begin
      i_top_pair = top_mem[feed_idx % R];
      i_bot_pair = bot_mem[feed_idx % R];
      feed_idx   = feed_idx + 1;
    end else begin
      feed_idx   = 0;
      i_top_pair = idle_top;
      i_bot_pair = idle_bot;
    end
  end

  logic [W-1:0] out_v [MAXN];
  int out_t [MAXN];
  int rd_t [MAXN];
  int intr_t [MAXN];
  int fd_t [MAXN];
  int out_cnt = 0, rd_cnt = 0, intr_cnt = 0, fd_cnt = 0, both_cnt = 0;

  // Output log: record every valid pixel, read cycle and pulse with its cycle number.
  always @(negedge i_clk) begin
    if (o_data_valid && out_cnt < MAXN) begin
      out_v[out_cnt] = o_data;
      out_t[out_cnt] = cyc;
      out_cnt = out_cnt + 1;
    end
    if (o_rd_data && rd_cnt < MAXN) begin
      rd_t[rd_cnt] = cyc;
      rd_cnt = rd_cnt + 1;
    end
    if (o_intr && intr_cnt < MAXN) begin
      intr_t[intr_cnt] = cyc;
      intr_cnt = intr_cnt + 1;
    end
    if (o_frame_done && fd_cnt < MAXN) begin
      fd_t[fd_cnt] = cyc;
      fd_cnt = fd_cnt + 1;
    end
    if (o_intr && o_frame_done) both_cnt = both_cnt + 1;
  end

  function automatic logic [2*W-1:0] pk(input int l, input int r);
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = W'(l);
    b = W'(r);
    return {a, b};
  endfunction

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < R; k++) begin
      top_mem[k] = pk((2*k) * 16, (2*k + 1) * 16);
      bot_mem[k] = pk((2*k + 30) * 16, (2*k + 31) * 16);
    end
  endtask

  // Start one line pair: raise ready until the burst begins, then drop it.
  task automatic run_one_pair(output int s_out, output int s_rd, output int s_intr, output int s_fd);
    bit got;
    s_out  = out_cnt;
    s_rd   = rd_cnt;
    s_intr = intr_cnt;
    s_fd   = fd_cnt;
    i_lines_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (o_rd_data) got = 1'b1;
    end
    i_lines_ready = 1'b0;
    total_cnt++;
    if (!got) $display("FAIL pair_start: o_rd_data=%0b required=1 within 20 cycles", o_rd_data);
    else pass_cnt++;
    repeat (30) step();
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      idle_top = (2*W)'($urandom);
      idle_bot = (2*W)'($urandom);
      i_lines_ready = 1'($urandom);
      repeat (2) step();
      total_cnt++; if (o_rd_data !== 1'b0) $display("FAIL reset_rd: got=%0b required=0", o_rd_data); else pass_cnt++;
      total_cnt++; if (o_data !== '0) $display("FAIL reset_data: got=%h required=0", o_data); else pass_cnt++;
      total_cnt++; if (o_data_valid !== 1'b0) $display("FAIL reset_valid: got=%0b required=0", o_data_valid); else pass_cnt++;
      total_cnt++; if (o_intr !== 1'b0) $display("FAIL reset_intr: got=%0b required=0", o_intr); else pass_cnt++;
      total_cnt++; if (o_frame_done !== 1'b0) $display("FAIL reset_frame_done: got=%0b required=0", o_frame_done); else pass_cnt++;
    end
    i_lines_ready = 1'b0;
    step();
    i_rst_n = 1'b1;
    repeat (3) step();
    total_cnt++; if (o_rd_data !== 1'b0) $display("FAIL post_reset_idle: o_rd_data=%0b required=0", o_rd_data); else pass_cnt++;
  endtask

  task automatic test_ramp();
    int s_out, s_rd, s_intr, s_fd, n;
    logic [W-1:0] exp_v;
    load_ramp();
    run_one_pair(s_out, s_rd, s_intr, s_fd);
    n = out_cnt - s_out;
    total_cnt++; if (n != 15) $display("FAIL ramp_count: got=%0d required=15", n); else pass_cnt++;
    for (int k = 0; k < 15 && k < n; k++) begin
      exp_v = W'((2*k + 31) * 16);
      total_cnt++;
      if (out_v[s_out + k] !== exp_v) $display("FAIL ramp_pixel%0d: got=%h required=%h", k, out_v[s_out + k], exp_v);
      else pass_cnt++;
    end
    total_cnt++; if (rd_cnt - s_rd != 15) $display("FAIL ramp_reads: got=%0d required=15", rd_cnt - s_rd); else pass_cnt++;
    total_cnt++; if (out_t[s_out] - rd_t[s_rd] != 2) $display("FAIL ramp_latency: got=%0d required=2", out_t[s_out] - rd_t[s_rd]); else pass_cnt++;
    total_cnt++; if (out_t[s_out + 14] - out_t[s_out] != 14) $display("FAIL ramp_contiguous: got=%0d required=14", out_t[s_out + 14] - out_t[s_out]); else pass_cnt++;
    total_cnt++; if (intr_cnt - s_intr != 1) $display("FAIL ramp_intr_count: got=%0d required=1", intr_cnt - s_intr); else pass_cnt++;
    total_cnt++; if (intr_t[s_intr] - rd_t[s_rd + 14] != 3) $display("FAIL ramp_intr_delay: got=%0d required=3", intr_t[s_intr] - rd_t[s_rd + 14]); else pass_cnt++;
    total_cnt++; if (fd_cnt - s_fd != 0) $display("FAIL ramp_no_frame_done: got=%0d required=0", fd_cnt - s_fd); else pass_cnt++;
  endtask

  task automatic test_signs();
    int s_out, s_rd, s_intr, s_fd, n;
    logic [2*W-1:0] vt [4];
    logic [2*W-1:0] vb [4];
    logic [W-1:0]   ve [4];
    vt[0] = pk(-80, -20);   vb[0] = pk(-48, -128); ve[0] = 13'h1FEC;
    vt[1] = pk(-16, 0);     vb[1] = pk(-32, -48);  ve[1] = 13'h0000;
    vt[2] = pk(-112, -96);  vb[2] = pk(56, -32);   ve[2] = 13'h0038;
    vt[3] = pk(64, -16);    vb[3] = pk(32, 48);    ve[3] = 13'h0040;
    for (int k = 0; k < R; k++) begin
      top_mem[k] = vt[k % 4];
      bot_mem[k] = vb[k % 4];
    end
    run_one_pair(s_out, s_rd, s_intr, s_fd);
    n = out_cnt - s_out;
    total_cnt++; if (n != 15) $display("FAIL signs_count: got=%0d required=15", n); else pass_cnt++;
    for (int k = 0; k < 15 && k < n; k++) begin
      total_cnt++;
      if (out_v[s_out + k] !== ve[k % 4]) $display("FAIL signs_pixel%0d: got=%h required=%h", k, out_v[s_out + k], ve[k % 4]);
      else pass_cnt++;
    end
  endtask

  task automatic test_ties();
    int s_out, s_rd, s_intr, s_fd, n;
    for (int k = 0; k < R; k++) begin
      top_mem[k] = pk(165, 165);
      bot_mem[k] = pk(165, 165);
    end
    run_one_pair(s_out, s_rd, s_intr, s_fd);
    n = out_cnt - s_out;
    total_cnt++; if (n != 15) $display("FAIL ties_count: got=%0d required=15", n); else pass_cnt++;
    for (int k = 0; k < 15 && k < n; k += 7) begin
      total_cnt++;
      if (out_v[s_out + k] !== 13'h0A5) $display("FAIL ties_pixel%0d: got=%h required=0a5", k, out_v[s_out + k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_ready_gating();
    int s_rd, s_out, s_intr;
    bit got;
    i_lines_ready = 1'b0;
    s_rd = rd_cnt;
    repeat (40) step();
    total_cnt++; if (rd_cnt - s_rd != 0) $display("FAIL gating_idle_reads: got=%0d required=0", rd_cnt - s_rd); else pass_cnt++;
    s_rd = rd_cnt; s_out = out_cnt; s_intr = intr_cnt;
    i_lines_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (o_rd_data) got = 1'b1;
    end
    total_cnt++; if (!got) $display("FAIL gating_start: o_rd_data=%0b required=1 within 20 cycles", o_rd_data); else pass_cnt++;
    repeat (2) step();
    i_lines_ready = 1'b0;
    repeat (2) step();
    i_lines_ready = 1'b1;
    repeat (3) step();
    i_lines_ready = 1'b0;
    repeat (30) step();
    total_cnt++; if (rd_cnt - s_rd != 15) $display("FAIL gating_burst_len: got=%0d required=15", rd_cnt - s_rd); else pass_cnt++;
    total_cnt++; if (rd_t[s_rd + 14] - rd_t[s_rd] != 14) $display("FAIL gating_burst_contig: got=%0d required=14", rd_t[s_rd + 14] - rd_t[s_rd]); else pass_cnt++;
    total_cnt++; if (out_cnt - s_out != 15) $display("FAIL gating_outputs: got=%0d required=15", out_cnt - s_out); else pass_cnt++;
    total_cnt++; if (intr_cnt - s_intr != 1) $display("FAIL gating_intr: got=%0d required=1", intr_cnt - s_intr); else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    int s_out, s_rd, rel;
    bit got;
    load_ramp();
    i_lines_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (o_rd_data) got = 1'b1;
    end
    total_cnt++; if (!got) $display("FAIL midrst_start: o_rd_data=%0b required=1 within 20 cycles", o_rd_data); else pass_cnt++;
    repeat (4) step();
    total_cnt++; if (o_data_valid !== 1'b1) $display("FAIL midrst_pre_valid: got=%0b required=1", o_data_valid); else pass_cnt++;
    #2;
    i_rst_n = 1'b0;
    #1;
    total_cnt++; if (o_rd_data !== 1'b0) $display("FAIL midrst_async_rd: got=%0b required=0", o_rd_data); else pass_cnt++;
    total_cnt++; if (o_data_valid !== 1'b0) $display("FAIL midrst_async_valid: got=%0b required=0", o_data_valid); else pass_cnt++;
    total_cnt++; if (o_data !== '0) $display("FAIL midrst_async_data: got=%h required=0", o_data); else pass_cnt++;
    repeat (2) step();
    s_out = out_cnt;
    s_rd  = rd_cnt;
    rel   = cyc;
    i_rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (out_cnt > s_out) got = 1'b1;
    end
    i_lines_ready = 1'b0;
    total_cnt++; if (!got) $display("FAIL midrst_restart: o_data_valid=%0b required=1 within 10 cycles", o_data_valid); else pass_cnt++;
    total_cnt++; if (rd_t[s_rd] - rel != 1) $display("FAIL midrst_rd_delay: got=%0d required=1", rd_t[s_rd] - rel); else pass_cnt++;
    total_cnt++; if (out_t[s_out] - rel != 3) $display("FAIL midrst_valid_delay: got=%0d required=3", out_t[s_out] - rel); else pass_cnt++;
    total_cnt++; if (out_v[s_out] !== W'(31 * 16)) $display("FAIL midrst_first_pixel: got=%h required=%h", out_v[s_out], W'(31 * 16)); else pass_cnt++;
    repeat (30) step();
    total_cnt++; if (out_cnt - s_out != 15) $display("FAIL midrst_outputs: got=%0d required=15", out_cnt - s_out); else pass_cnt++;
  endtask

  task automatic test_full_frame();
    int s_out, s_intr, s_fd, s_both;
    bit got;
    i_lines_ready = 1'b0;
    step();
    i_rst_n = 1'b0;
    repeat (2) step();
    i_rst_n = 1'b1;
    step();
    i_lines_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      s_out = out_cnt; s_intr = intr_cnt; s_fd = fd_cnt; s_both = both_cnt;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
        step();
        if (fd_cnt > s_fd) got = 1'b1;
      end
      if (f == 1) i_lines_ready = 1'b0;
      total_cnt++; if (!got) $display("FAIL frame%0d_done_timeout: o_frame_done=%0b required=1 within 400 cycles", f, o_frame_done); else pass_cnt++;
      total_cnt++; if (out_cnt - s_out != 225) $display("FAIL frame%0d_outputs: got=%0d required=225", f, out_cnt - s_out); else pass_cnt++;
      total_cnt++; if (intr_cnt - s_intr != 15) $display("FAIL frame%0d_intr: got=%0d required=15", f, intr_cnt - s_intr); else pass_cnt++;
      total_cnt++; if (fd_t[s_fd] - intr_t[s_intr + 14] != 1) $display("FAIL frame%0d_fd_after_intr: got=%0d required=1", f, fd_t[s_fd] - intr_t[s_intr + 14]); else pass_cnt++;
      total_cnt++; if (both_cnt - s_both != 0) $display("FAIL frame%0d_pulse_overlap: got=%0d required=0", f, both_cnt - s_both); else pass_cnt++;
    end
    s_fd = fd_cnt;
    repeat (20) step();
    total_cnt++; if (fd_cnt - s_fd != 0) $display("FAIL frame_single_done: got=%0d required=0", fd_cnt - s_fd); else pass_cnt++;
  endtask

  initial begin
    load_ramp();
    test_reset();
    test_ramp();
    test_signs();
    test_ties();
    test_ready_gating();
    test_reset_mid_read();
    test_full_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
